instr_assembler: RTL
====================

# instr_assembler

Parametrised instruction register that assembles a multi-byte instruction from a byte-wide fetch stream and presents it to the decoder as one word. It sits between the program-memory/fetch path and the control unit. It adds the following:
- configurable byte width and maximum length;
- optional variable-length instructions, with the length encoded in the first byte;
- valid/ready handshakes on both sides;
- a one-deep output buffer, so the next instruction can be collected while the decoder still holds the current one.

## Interface
Parameters:
- BYTE_W, 8: width of one fetch byte.
- MAX_BYTES, 3: maximum instruction length in bytes (2..4).
- VAR_LEN, 1: if 1, length comes from the first byte's top 2 bits. If 0, every instruction is MAX_BYTES long.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  payload byte offered.
- in_ready  out  1  byte accepted on a cycle where in_valid && in_ready.
- payload  in  BYTE_W  fetch byte.
- flush  in  1  discards any partially assembled instruction (branch taken).
- out_valid  out  1  instr holds a complete instruction.
- out_ready  in  1  decoder consumes instr when out_valid && out_ready.
- instr  out  MAX_BYTES*BYTE_W  assembled instruction. First byte is in the MSBs; unused trailing bytes are zero.
- instr_len  out  2  byte count minus 1.
- len_err  out  1  one-cycle pulse when an illegal length field is received.

## Operation
- States: IDLE (awaiting first byte) and COLLECT (awaiting remaining bytes). Internal signals:
  - byte counter cnt, 2 bits;
  - target length tlen;
  - collection register col.
- Length rule:
  - VAR_LEN=1: tlen = payload[BYTE_W-1:BYTE_W-2] + 1, taken from the first byte.
  - VAR_LEN=0: tlen = MAX_BYTES.
- Illegal length (tlen > MAX_BYTES, or VAR_LEN=1 with MAX_BYTES < 4 and field too large):
  - the byte is accepted and dropped;
  - len_err pulses for one cycle;
  - the state stays IDLE.
- IDLE, first byte accepted:
  - if tlen==1, the instruction completes immediately;
  - otherwise col[top byte] = payload, cnt=1, and the state moves to COLLECT.
- COLLECT: each accepted byte is stored at byte slot cnt (counted from the MSB) and cnt increments. When cnt+1 == tlen, the instruction completes and the state returns to IDLE.
- Completion: the output register is loaded with col merged with the final byte. Slots ≥ tlen are zeroed. instr_len = tlen-1 and out_valid is set.
- in_ready is 0 only when the next accepted byte would complete an instruction while out_valid && !out_ready. Non-final bytes are always accepted.
- Simultaneous consume and complete is allowed: the output register is reloaded and out_valid stays 1.
- out_valid clears on consume when no new completion occurs in the same cycle.
- flush:
  - forces IDLE and cnt=0;
  - any byte presented in the same cycle is ignored, and in_ready is 0 during flush;
  - the output register and out_valid are unaffected;
  - flush has priority over completion.
- instr and instr_len are stable while out_valid && !out_ready.

## Timing
- Reset values: state IDLE, cnt 0, col 0, instr 0, instr_len 0, out_valid 0, len_err 0, in_ready 1 after reset.
- Latency: final byte accepted on edge t gives out_valid=1 after edge t (visible in cycle t+1).
- Throughput is one byte per cycle sustained when out_ready=1, e.g. 3-byte instructions complete every 3 cycles.
- in_ready is combinational from state, cnt, tlen, out_valid, out_ready and flush. It never depends on in_valid.
- len_err is registered: a high pulse in the cycle after the illegal byte is accepted.
- rst_n low mid-instruction: partial bytes are discarded and a pending output is dropped. Reset has priority over flush.
- cnt never exceeds MAX_BYTES-1. No wrap-around is possible.

## Structure
- Shared package holds:
  - the state enum (ST_IDLE, ST_COLLECT);
  - the length-field width constant (LEN_FIELD_W=2);
  - a function decoding the first byte to tlen.
- The output buffer is a natural sub-module, instr_out_buf: a one-entry valid/ready register with a load port.
- The assembler FSM and collection register stay in the top module.

## Test plan
- BYTE_W=8, MAX_BYTES=3, VAR_LEN=0, out_ready=1; bytes 0xA1,0xB2,0xC3 on consecutive cycles -> instr=0xA1B2C3, instr_len=2, out_valid one cycle after 0xC3 accepted.
- VAR_LEN=1; first byte 0x05 (len 1), then 0x4A,0x11 (len 2) -> instr=0x050000 with len 0, then instr=0x4A1100 with len 1.
- VAR_LEN=1, MAX_BYTES=3; first byte 0xC0 (len 4) -> len_err pulse, no out_valid, next byte treated as a first byte.
- out_ready=0 with first instruction pending; stream a second 3-byte instruction:
  - the first two bytes are accepted;
  - in_ready=0 on the third byte until out_ready=1;
  - the first instruction is consumed and the second is loaded in the same edge, with out_valid staying 1.
- Flush after 2 of 3 bytes, then 0x01,0x02,0x03 -> instr=0x010203. Partial bytes are never emitted.
- rst_n low for 1 cycle while out_valid=1 and cnt=1 -> all outputs at reset values; the next 3 bytes assemble normally.

Source files
------------

// File: rtl/instr_assembler_pkg.sv
// Shared types and helpers for the instruction assembler: FSM states and
// the first-byte length decode.
package instr_assembler_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam int LEN_FIELD_W = 2;

    // Target length in bytes (1..4); the caller flags values above max_bytes as illegal.
    function automatic logic [2:0] decode_tlen(input logic [LEN_FIELD_W-1:0] field,
                                               input bit var_len,
                                               input int max_bytes);
        if (var_len)
            return {1'b0, field} + 3'd1;
        else
            return 3'(max_bytes);
    endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Fetch-side and decoder-side signals of the instruction assembler.
// Handshake: a byte moves when in_valid && in_ready; an instruction moves when out_valid && out_ready.
interface instr_assembler_if #(
    parameter int BYTE_W    = 8,
    parameter int MAX_BYTES = 3
);
    logic                        in_valid;
    logic                        in_ready;
    logic [BYTE_W-1:0]           payload;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [MAX_BYTES*BYTE_W-1:0] instr;
    logic [1:0]                  instr_len;
    logic                        len_err;

    modport slave (
        input  in_valid, payload, flush, out_ready,
        output in_ready, out_valid, instr, instr_len, len_err
    );

    modport master (
        output in_valid, payload, flush, out_ready,
        input  in_ready, out_valid, instr, instr_len, len_err
    );
endinterface

// File: rtl/instr_assembler_out_buf.sv
// One-entry output register holding a completed instruction until the decoder takes it.
module instr_out_buf #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [1:0]        load_len,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        len
);

    // The caller only loads when the entry is empty or being consumed this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            len   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            len   <= load_len;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_assembler.sv
// Assembles multi-byte instructions from a byte-wide fetch stream and hands
// them to the decoder through a one-deep output buffer.
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter int BYTE_W    = 8,
    parameter int MAX_BYTES = 3,
    parameter int VAR_LEN   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_assembler_if.slave   bus,
    output state_t             dbg_state
);

    localparam int INSTR_W = MAX_BYTES * BYTE_W;

    state_t             state;
    logic [1:0]         cnt;
    logic [2:0]         tlen;
    logic [INSTR_W-1:0] col;
    logic               len_err_q;

    logic [2:0]         first_tlen;
    logic               first_bad;
    logic               final_byte;
    logic               out_blocked;
    logic               ready;
    logic               accept;
    logic               complete;
    logic [1:0]         slot;
    logic [2:0]         cur_tlen;
    logic [INSTR_W-1:0] merged;

    logic               buf_valid;
    logic [INSTR_W-1:0] buf_data;
    logic [1:0]         buf_len;

    assign first_tlen = decode_tlen(bus.payload[BYTE_W-1 -: LEN_FIELD_W], VAR_LEN != 0, MAX_BYTES);
    assign first_bad  = first_tlen > 3'(MAX_BYTES);
    assign cur_tlen   = (state == ST_IDLE) ? first_tlen : tlen;
    assign slot       = (state == ST_IDLE) ? 2'd0 : cnt;

    // In IDLE a legal length-1 first byte completes on its own, so readiness
    // there looks at the offered byte's length field.
    assign final_byte  = (state == ST_IDLE) ? (!first_bad && first_tlen == 3'd1)
                                            : (({1'b0, cnt} + 3'd1) == tlen);
    assign out_blocked = buf_valid && !bus.out_ready;
    assign ready       = !bus.flush && !(final_byte && out_blocked);
    assign accept      = bus.in_valid && ready;
    assign complete    = accept && final_byte;

    // Slots before the current one come from col, the current slot takes the
    // payload, and everything after it is zero.
    always_comb begin
        merged = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i == int'(slot))
                merged[INSTR_W-1-i*BYTE_W -: BYTE_W] = bus.payload;
            else if (state == ST_COLLECT && i < int'(slot))
                merged[INSTR_W-1-i*BYTE_W -: BYTE_W] = col[INSTR_W-1-i*BYTE_W -: BYTE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tlen      <= '0;
            col       <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (bus.flush) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (accept) begin
                if (state == ST_IDLE) begin
                    if (first_bad) begin
                        len_err_q <= 1'b1;
                    end else if (!final_byte) begin
                        state <= ST_COLLECT;
                        cnt   <= 2'd1;
                        tlen  <= first_tlen;
                        col   <= merged;
                    end
                end else if (final_byte) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    col   <= '0;
                end else begin
                    cnt <= cnt + 2'd1;
                    col <= merged;
                end
            end
        end
    end

    instr_out_buf #(
        .DATA_W (INSTR_W)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (complete),
        .load_data (merged),
        .load_len  (2'(cur_tlen - 3'd1)),
        .ready     (bus.out_ready),
        .valid     (buf_valid),
        .data      (buf_data),
        .len       (buf_len)
    );

    assign bus.in_ready  = ready;
    assign bus.out_valid = buf_valid;
    assign bus.instr     = buf_data;
    assign bus.instr_len = buf_len;
    assign bus.len_err   = len_err_q;
    assign dbg_state     = state;

endmodule
